gpio_sel_sequencer: RTL and testbench

- Configuration controller for the 38-pin GPIO output mux, which selects one of 13 project teams per pin through 4-bit select lines.
- Software writes per-pin select values into shadow registers, then issues a commit.
- On commit the block performs a break-before-make sequence: pins that change owner are forced to input (oeb=1), the active selects are updated, and the force is released.
- This prevents two projects from momentarily driving a pad during reassignment. Outputs feed the mux select lines and an oeb override stage.

---
 rtl/gpio_sel_sequencer_if.sv | 28 ++
 rtl/gpio_sel_sequencer.sv | 88 ++++++++
 tb/tb_gpio_sel_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_sel_sequencer_if.sv
// gpio_sel_sequencer_if: write/commit/readback bus and mux control outputs of the GPIO select sequencer
interface gpio_sel_sequencer_if #(
  parameter int NUM_PINS = 38,
  parameter int SEL_W    = 4
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [5:0]                wr_pin;
  logic [SEL_W-1:0]          wr_sel;
  logic                      commit;
  logic                      busy;
  logic                      commit_done;
  logic                      err;
  logic                      err_clr;
  logic [NUM_PINS*SEL_W-1:0] pin_sel;
  logic [NUM_PINS-1:0]       pin_force_oeb;
  logic [5:0]                rd_pin;
  logic [SEL_W-1:0]          rd_shadow;
  logic [SEL_W-1:0]          rd_active;
  modport master (
    output wr_valid, wr_pin, wr_sel, commit, err_clr, rd_pin,
    input  wr_ready, busy, commit_done, err, pin_sel, pin_force_oeb, rd_shadow, rd_active
  );
  modport slave (
    input  wr_valid, wr_pin, wr_sel, commit, err_clr, rd_pin,
    output wr_ready, busy, commit_done, err, pin_sel, pin_force_oeb, rd_shadow, rd_active
  );
endinterface

// File: rtl/gpio_sel_sequencer.sv
// gpio_sel_sequencer: shadow/active GPIO mux selects with break-before-make commit sequencing
module gpio_sel_sequencer #(
  parameter int NUM_PINS     = 38,
  parameter int NUM_PROJ     = 13,
  parameter int SEL_W        = 4,
  parameter int BREAK_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  gpio_sel_sequencer_if.slave        s
);
  localparam int CW = $clog2(BREAK_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, BREAK, APPLY, RELEASE} state_t;
  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [SEL_W-1:0]    shadow    [NUM_PINS];
  logic [SEL_W-1:0]    shadow_nx [NUM_PINS];
  logic [SEL_W-1:0]    active    [NUM_PINS];
  logic [NUM_PINS-1:0] mask;
  logic [NUM_PINS-1:0] force_q;
  logic                wr_fire;
  logic                wr_ok;
  logic                done_q;
  logic                err_q;
  logic                start;
  // post-write shadow, so a commit on the same edge as a write sees that write
  always_comb begin
    wr_fire = s.wr_valid && state == IDLE;
    wr_ok   = 32'(s.wr_pin) < NUM_PINS && 32'(s.wr_sel) < NUM_PROJ;
    start   = state == IDLE && s.commit;
    for (int i = 0; i < NUM_PINS; i++) begin
      shadow_nx[i] = (wr_fire && wr_ok && s.wr_pin == 6'(i)) ? s.wr_sel : shadow[i];
      mask[i]      = shadow_nx[i] != active[i];
    end
  end
  // next-state: unchanged commits skip the break phase entirely
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (s.commit ? (|mask ? BREAK : APPLY) : IDLE) :
               state == BREAK ? (cnt == '0 ? APPLY : BREAK) :
               state == APPLY ? RELEASE : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // shadow/active selects, forces, break counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      force_q <= '1;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        shadow[i] <= shadow_nx[i];
        active[i] <= state == APPLY ? shadow[i] : active[i];
      end
      force_q <= state == RELEASE ? '0 : start ? force_q | mask : force_q;
      cnt     <= (start && |mask) ? CW'(BREAK_CYCLES - 1) :
                 (state == BREAK && cnt != '0) ? cnt - CW'(1) : cnt;
      done_q  <= state == RELEASE;
      err_q   <= (wr_fire && !wr_ok) || (err_q && !s.err_clr);
    end
  end
  // outputs and combinational readback; out-of-range readback reads as 0
  always_comb begin
    s.wr_ready      = state == IDLE;
    s.busy          = state != IDLE;
    s.commit_done   = done_q;
    s.err           = err_q;
    s.pin_force_oeb = force_q;
    s.pin_sel       = '0;
    s.rd_shadow     = '0;
    s.rd_active     = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      s.pin_sel[i*SEL_W +: SEL_W] = active[i];
      if (s.rd_pin == 6'(i)) begin
        s.rd_shadow = shadow[i];
        s.rd_active = active[i];
      end
    end
  end
endmodule

// File: tb/tb_gpio_sel_sequencer.sv
// tb_gpio_sel_sequencer: scoreboard bench for the GPIO select commit sequencer
module tb_gpio_sel_sequencer;
  localparam int NP = 38;
  logic tb_clk;
  logic rst;
  int checks;
  int failures;
  logic [3:0]   m_shadow [NP];
  logic [3:0]   m_active [NP];
  logic [NP-1:0] m_force;
  logic [151:0] sb_q [$];
  logic [151:0] sb_exp;
  gpio_sel_sequencer_if #(.NUM_PINS(NP), .SEL_W(4)) bus ();
  gpio_sel_sequencer #(.NUM_PINS(NP), .NUM_PROJ(13), .SEL_W(4), .BREAK_CYCLES(4)) dut (
    .clk(tb_clk),
    .rst(rst),
    .s(bus)
  );
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [151:0] pack_sel();
    logic [151:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*4 +: 4] = m_active[i];
    return r;
  endfunction
  task automatic reset_model();
    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_force = '1;
  endtask
  task automatic rd_chk(input int pin);
    bus.rd_pin = 6'(pin);
    #1;
    chk($sformatf("rd_shadow%0d", pin), bus.rd_shadow, pin < NP ? m_shadow[pin] : 4'd0);
    chk($sformatf("rd_active%0d", pin), bus.rd_active, pin < NP ? m_active[pin] : 4'd0);
  endtask
  task automatic do_write(input int pin, input int sel);
    int n;
    n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_pin   = 6'(pin);
    bus.wr_sel   = 4'(sel);
    while (!bus.wr_ready && n < 30) begin
      @(negedge tb_clk);
      n++;
    end
    chk("wr_ready_wait", n < 30, 1);
    @(negedge tb_clk);
    bus.wr_valid = 1'b0;
    if (pin < NP && sel < 13) m_shadow[pin] = 4'(sel);
  endtask
  task automatic run_commit(input bit with_wr, input int pin, input int sel);
    logic [NP-1:0] mask, fexp;
    logic [151:0]  old_sel, new_sel;
    int lat, k;
    bus.commit = 1'b1;
    if (with_wr) begin
      bus.wr_valid = 1'b1;
      bus.wr_pin   = 6'(pin);
      bus.wr_sel   = 4'(sel);
      if (pin < NP && sel < 13) m_shadow[pin] = 4'(sel);
    end
    old_sel = pack_sel();
    for (int i = 0; i < NP; i++) mask[i] = m_shadow[i] != m_active[i];
    fexp = m_force | mask;
    lat  = mask != '0 ? 7 : 3;
    for (int i = 0; i < NP; i++) m_active[i] = m_shadow[i];
    new_sel = pack_sel();
    m_force = '0;
    sb_q.push_back(new_sel);
    k = 0;
    do begin
      @(negedge tb_clk);
      k++;
      if (k == 1) begin
        bus.commit = 1'b0;
        if (with_wr) bus.wr_valid = 1'b0;
        chk("busy_start", bus.busy, 1);
      end
      if (!bus.commit_done) chk("force_hold", bus.pin_force_oeb, fexp);
      if (k == lat - 2) chk("sel_old", bus.pin_sel, old_sel);
      if (k == lat - 1) chk("sel_new", bus.pin_sel, new_sel);
    end while (!bus.commit_done && k < 20);
    chk("commit_lat", k, lat);
    @(negedge tb_clk);
    chk("done_pulse", bus.commit_done, 0);
  endtask
  always @(negedge tb_clk)
    if (bus.commit_done) begin
      chk("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        chk("done_sel", bus.pin_sel, sb_exp);
        chk("done_force", bus.pin_force_oeb, 0);
        chk("done_busy", bus.busy, 0);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_pin   = '0;
    bus.wr_sel   = '0;
    bus.commit   = 1'b0;
    bus.err_clr  = 1'b0;
    bus.rd_pin   = '0;
    reset_model();
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    chk("rst_force", bus.pin_force_oeb, {NP{1'b1}});
    chk("rst_sel", bus.pin_sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.wr_ready, 1);
    chk("rst_done", bus.commit_done, 0);
    run_commit(0, 0, 0);
    do_write(5, 7);
    do_write(37, 12);
    run_commit(0, 0, 0);
    rd_chk(5);
    rd_chk(37);
    do_write(40, 3);
    chk("err_pin", bus.err, 1);
    rd_chk(40);
    bus.err_clr = 1'b1;
    @(negedge tb_clk);
    bus.err_clr = 1'b0;
    chk("err_clr", bus.err, 0);
    do_write(2, 13);
    chk("err_sel", bus.err, 1);
    rd_chk(2);
    bus.err_clr = 1'b1;
    @(negedge tb_clk);
    chk("err_clr2", bus.err, 0);
    do_write(40, 3);
    bus.err_clr = 1'b0;
    chk("err_set_wins", bus.err, 1);
    bus.err_clr = 1'b1;
    @(negedge tb_clk);
    bus.err_clr = 1'b0;
    chk("err_clr3", bus.err, 0);
    do_write(3, 4);
    fork
      run_commit(0, 0, 0);
      begin : held
        int n;
        repeat (2) @(negedge tb_clk);
        bus.commit   = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_pin   = 6'd10;
        bus.wr_sel   = 4'd6;
        chk("ready_busy", bus.wr_ready, 0);
        @(negedge tb_clk);
        bus.commit = 1'b0;
        chk("ready_busy2", bus.wr_ready, 0);
        n = 0;
        while (!bus.commit_done && n < 20) begin
          @(negedge tb_clk);
          n++;
        end
        chk("held_done_seen", n < 20, 1);
        chk("ready_idle", bus.wr_ready, 1);
        bus.rd_pin = 6'd10;
        #1;
        chk("held_not_landed", bus.rd_shadow, 0);
        @(negedge tb_clk);
        bus.wr_valid = 1'b0;
        m_shadow[10] = 4'd6;
      end
    join
    rd_chk(10);
    @(negedge tb_clk);
    chk("no_recommit", bus.busy, 0);
    run_commit(1, 0, 9);
    rd_chk(0);
    do_write(20, 5);
    bus.commit = 1'b1;
    @(negedge tb_clk);
    bus.commit = 1'b0;
    @(negedge tb_clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_force", bus.pin_force_oeb, {NP{1'b1}});
    chk("arst_sel", bus.pin_sel, 0);
    chk("arst_busy", bus.busy, 0);
    reset_model();
    @(negedge tb_clk);
    rst = 1'b0;
    rd_chk(20);
    do_write(20, 5);
    run_commit(0, 0, 0);
    rd_chk(20);
    @(negedge tb_clk);
    chk("sb_drain", sb_q.size(), 0);
    chk("end_err", bus.err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
